partial_sum_sched: RTL and testbench



---
 rtl/partial_sum_sched.sv | 164 ++++++++++++++++
 tb/tb_partial_sum_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/partial_sum_sched.sv
// Purpose : time-shares one 108-bit three-input adder to fold six aligned 45-bit partial products into res_0/res_1 (and sum).
// Latency : out_valid rises 2 edges after capture (3 with FINAL_SUM_EN); one job per 4 cycles (5) with out_ready held high.
// Backpr. : results and out_valid are held in DONE until out_ready; in_ready is low in every state but IDLE.
// Option  : define FINAL_SUM_EN to add the PASS2 state and the sum port (sum = res_0 + res_1 mod 2^108).
module partial_sum_sched #(
  parameter int SIZE  = 45,
  parameter int RADIX = 54
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE-1:0]      a_0,
  input  logic [SIZE-1:0]      a_1,
  input  logic [SIZE-1:0]      a_2,
  input  logic [SIZE-1:0]      a_3,
  input  logic [SIZE-1:0]      a_4,
  input  logic [SIZE-1:0]      a_5,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*RADIX-1:0]   res_0,
  output logic [2*RADIX-1:0]   res_1,
`ifdef FINAL_SUM_EN
  output logic [2*RADIX-1:0]   sum,
`endif
  output logic                 busy
);

  localparam int W = 2 * RADIX;

  // Fixed limb offsets of each partial product inside the 108-bit result.
  localparam int SH_1 = 18;
  localparam int SH_2 = 36;
  localparam int SH_3 = 27;
  localparam int SH_4 = 45;
  localparam int SH_5 = 63;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS0 = 3'd1,
    PASS1 = 3'd2,
`ifdef FINAL_SUM_EN
    PASS2 = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t state;

  // Captured operands; the input buses are not looked at after the handshake.
  logic [SIZE-1:0] op_0, op_1, op_2, op_3, op_4, op_5;

  logic [W-1:0] al_0, al_1, al_2, al_3, al_4, al_5;
  logic [W-1:0] add_x, add_y, add_z, add_s;

  assign al_0 = W'(op_0);
  assign al_1 = W'(op_1) << SH_1;
  assign al_2 = W'(op_2) << SH_2;
  assign al_3 = W'(op_3) << SH_3;
  assign al_4 = W'(op_4) << SH_4;
  assign al_5 = W'(op_5) << SH_5;

  // The one shared adder; carry out of bit 107 is intentionally dropped.
  assign add_s = add_x + add_y + add_z;

  // Route the adder inputs according to the current pass.
  always_comb begin
    add_x = '0;
    add_y = '0;
    add_z = '0;
    case (state)
      PASS0: begin
        add_x = al_0;
        add_y = al_1;
        add_z = al_2;
      end
      PASS1: begin
        add_x = al_3;
        add_y = al_4;
        add_z = al_5;
      end
`ifdef FINAL_SUM_EN
      PASS2: begin
        add_x = res_0;
        add_y = res_1;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer: capture, run the passes, hold results until accepted. Handshake outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res_0     <= '0;
      res_1     <= '0;
`ifdef FINAL_SUM_EN
      sum       <= '0;
`endif
      op_0      <= '0;
      op_1      <= '0;
      op_2      <= '0;
      op_3      <= '0;
      op_4      <= '0;
      op_5      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_0     <= a_0;
            op_1     <= a_1;
            op_2     <= a_2;
            op_3     <= a_3;
            op_4     <= a_4;
            op_5     <= a_5;
            state    <= PASS0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        PASS0: begin
          res_0 <= add_s;
          state <= PASS1;
        end
        PASS1: begin
          res_1 <= add_s;
`ifdef FINAL_SUM_EN
          state <= PASS2;
`else
          state     <= DONE;
          out_valid <= 1'b1;
`endif
        end
`ifdef FINAL_SUM_EN
        PASS2: begin
          sum       <= add_s;
          state     <= DONE;
          out_valid <= 1'b1;
        end
`endif
        DONE: begin
          // in_valid is deliberately not looked at here: a new job waits for IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_partial_sum_sched.sv
// Scoreboard bench for partial_sum_sched: directed jobs with hand-computed results plus a random stream.
// Expectations are queued at issue time and popped by a monitor on each accepted result.
`timescale 1ns/1ps
module tb_partial_sum_sched;

`ifdef FINAL_SUM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [44:0]  a_0, a_1, a_2, a_3, a_4, a_5;
  logic         out_valid;
  logic         out_ready;
  logic [107:0] res_0, res_1;
  logic         busy;
`ifdef FINAL_SUM_EN
  logic [107:0] sum;
`endif

  typedef struct {
    logic [107:0] r0;
    logic [107:0] r1;
    logic [107:0] s;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   stream_done;

  localparam logic [44:0]  ONES    = 45'h1FFF_FFFF_FFFF;
  localparam logic [107:0] P63     = 108'h8000000000000000;
  localparam logic [107:0] ONES_63 = 108'hFFFFFFFFFFF8000000000000000;

  partial_sum_sched #(.SIZE(45), .RADIX(54)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_0       (a_0),
    .a_1       (a_1),
    .a_2       (a_2),
    .a_3       (a_3),
    .a_4       (a_4),
    .a_5       (a_5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_0     (res_0),
    .res_1     (res_1),
`ifdef FINAL_SUM_EN
    .sum       (sum),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: aligned operand sums, wrapped to 108 bits.
  function automatic exp_t model(input logic [5:0][44:0] a);
    exp_t e;
    e.r0 = 108'(a[0]) + (108'(a[1]) << 18) + (108'(a[2]) << 36);
    e.r1 = (108'(a[3]) << 27) + (108'(a[4]) << 45) + (108'(a[5]) << 63);
    e.s  = e.r0 + e.r1;
    return e;
  endfunction

  function automatic exp_t mk(input logic [107:0] r0, input logic [107:0] r1, input logic [107:0] s);
    exp_t e;
    e.r0 = r0;
    e.r1 = r1;
    e.s  = s;
    return e;
  endfunction

  // Monitor: each accepted result is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: result %0h/%0h presented with no job outstanding", res_0, res_1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_0", 128'(res_0), 128'(e.r0));
        check("res_1", 128'(res_1), 128'(e.r1));
`ifdef FINAL_SUM_EN
        check("sum", 128'(sum), 128'(e.s));
`endif
      end
    end
  end

  // Present an operand set and hold in_valid until it is captured; returns #1 after the capture edge.
  task automatic issue(input logic [5:0][44:0] a);
    bit got;
    got = 1'b0;
    a_0 = a[0]; a_1 = a[1]; a_2 = a[2];
    a_3 = a[3]; a_4 = a[4]; a_5 = a[5];
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check(name, 128'(sb.size()), 128'(0));
  endtask

  task automatic job(input logic [5:0][44:0] a, input exp_t e, input string name);
    sb.push_back(e);
    issue(a);
    wait_drain(name);
  endtask

  initial begin
    logic [5:0][44:0] a;
    logic [107:0] h0, h1;
    bit stable, rdy_low;
    int cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stream_done = 1'b0;
    a_0 = '0; a_1 = '0; a_2 = '0; a_3 = '0; a_4 = '0; a_5 = '0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_res_0", 128'(res_0), 128'(0));
    check("rst_res_1", 128'(res_1), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Alignment and hand-computed vectors.
    a = '0; a[0] = 45'd1;
    job(a, mk(108'd1, 108'd0, 108'd1), "drain_a0");
    a = '0; a[5] = 45'd1;
    job(a, mk(108'd0, P63, P63), "drain_a5");
    a = '0; a[5] = ONES;
    job(a, mk(108'd0, ONES_63, ONES_63), "drain_a5_ones");
    a = '0; a[0] = 45'd3; a[1] = 45'd1; a[2] = 45'd1; a[3] = 45'd1; a[4] = 45'd2;
    job(a, mk(108'h1000040003, 108'h400008000000, 108'h401008040003), "drain_mixed");
    // res_0 = 2^63, res_1 = 2^108 - 2^63 -> sum wraps to exactly 0.
    a = '0; a[0] = 45'h40000; a[1] = ONES; a[5] = ONES;
    job(a, mk(P63, ONES_63, 108'd0), "drain_wrap");
    for (int i = 0; i < 6; i++) a[i] = ONES;
    job(a, model(a), "drain_all_ones");

    // Latency and back-pressure with in_valid held high during DONE.
    out_ready = 1'b0;
    a = '0; a[0] = 45'h123; a[3] = 45'h456;
    sb.push_back(model(a));
    issue(a);
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 128'(cyc), 128'(LAT));
    h0 = res_0; h1 = res_1;
    stable = 1'b1; rdy_low = 1'b1;
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (res_0 !== h0 || res_1 !== h1 || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'(1));
    check("bp_in_ready_low", 128'(rdy_low), 128'(1));
    // out_ready and in_valid together in DONE: only the release happens.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("done_release_in_ready", 128'(in_ready), 128'(1));
    check("done_release_out_valid", 128'(out_valid), 128'(0));
    check("done_release_busy", 128'(busy), 128'(0));
    wait_drain("drain_bp");

    // Reset during PASS1: job aborted, nothing presented.
    a = '0; a[0] = 45'd5; a[3] = 45'd7;
    issue(a);
    @(posedge clk);
    #1;
    check("pre_rst_res_0", 128'(res_0), 128'(5));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_res_0", 128'(res_0), 128'(0));
    check("mid_rst_res_1", 128'(res_1), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    a = '0; a[2] = 45'h1; a[4] = 45'h1;
    job(a, mk(108'h1000000000, 108'h200000000000, 108'h201000000000), "drain_after_rst");

    // Random stream with random out_ready; drops or duplicates surface in the scoreboard.
    fork
      begin
        for (int j = 0; j < 20; j++) begin
          for (int i = 0; i < 6; i++) a[i] = 45'({$urandom(), $urandom()});
          sb.push_back(model(a));
          issue(a);
        end
        wait_drain("drain_stream");
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 128'(sb.size()), 128'(0));
    check("final_out_valid", 128'(out_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
